// File: rtl/hilo_control_sequencer.sv
// hilo_control_sequencer
//   Decodes the D-stage instruction, registers the control bundle into the D->E boundary
//   and sequences the multi-cycle MULT/DIV unit. While the unit is busy, HI/LO users in D
//   are held (stallD) and bubbles are injected into E.
//
// Ports
//   clock, reset            : rising-edge clock, asynchronous active-low reset
//   opcode, funct, reg_rt_id: D-stage instruction fields
//   validD                  : D holds a real instruction
//   flushE, stallE          : discard D / freeze the E bundle
//   *E                      : registered control bundle for the execute stage
//   stallD                  : hold PC and the D register (combinational)
//   hilo_busy, hilo_done    : unit not idle / pulse on the final busy cycle
module hilo_control_sequencer #(
    parameter int unsigned DIV_CYCLES  = 32,
    parameter int unsigned MULT_CYCLES = 4,
    parameter int unsigned CNT_W       = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic [4:0] reg_rt_id,
    input  logic       validD,
    input  logic       flushE,
    input  logic       stallE,
    output logic       reg_writeE,
    output logic       mem_to_regE,
    output logic       mem_writeE,
    output logic       alu_srcE,
    output logic       reg_destE,
    output logic       syscallE,
    output logic       is_byteE,
    output logic       link_regE,
    output logic [3:0] alu_opE,
    output logic [1:0] hilo_opE,
    output logic       validE,
    output logic       illegalE,
    output logic       stallD,
    output logic       hilo_busy,
    output logic       hilo_done
);

    // Opcodes
    localparam logic [5:0] OpSpecial = 6'h00;
    localparam logic [5:0] OpRegimm  = 6'h01;
    localparam logic [5:0] OpJ       = 6'h02;
    localparam logic [5:0] OpJal     = 6'h03;
    localparam logic [5:0] OpBeq     = 6'h04;
    localparam logic [5:0] OpBne     = 6'h05;
    localparam logic [5:0] OpBlez    = 6'h06;
    localparam logic [5:0] OpBgtz    = 6'h07;
    localparam logic [5:0] OpAddi    = 6'h08;
    localparam logic [5:0] OpAddiu   = 6'h09;
    localparam logic [5:0] OpSlti    = 6'h0A;
    localparam logic [5:0] OpSltiu   = 6'h0B;
    localparam logic [5:0] OpAndi    = 6'h0C;
    localparam logic [5:0] OpOri     = 6'h0D;
    localparam logic [5:0] OpXori    = 6'h0E;
    localparam logic [5:0] OpLui     = 6'h0F;
    localparam logic [5:0] OpLb      = 6'h20;
    localparam logic [5:0] OpLw      = 6'h23;
    localparam logic [5:0] OpLbu     = 6'h24;
    localparam logic [5:0] OpSb      = 6'h28;
    localparam logic [5:0] OpSw      = 6'h2B;

    // SPECIAL funct codes
    localparam logic [5:0] FnSll     = 6'h00;
    localparam logic [5:0] FnSrl     = 6'h02;
    localparam logic [5:0] FnSra     = 6'h03;
    localparam logic [5:0] FnSllv    = 6'h04;
    localparam logic [5:0] FnSrlv    = 6'h06;
    localparam logic [5:0] FnSrav    = 6'h07;
    localparam logic [5:0] FnJr      = 6'h08;
    localparam logic [5:0] FnJalr    = 6'h09;
    localparam logic [5:0] FnSyscall = 6'h0C;
    localparam logic [5:0] FnMfhi    = 6'h10;
    localparam logic [5:0] FnMthi    = 6'h11;
    localparam logic [5:0] FnMflo    = 6'h12;
    localparam logic [5:0] FnMtlo    = 6'h13;
    localparam logic [5:0] FnMult    = 6'h18;
    localparam logic [5:0] FnMultu   = 6'h19;
    localparam logic [5:0] FnDiv     = 6'h1A;
    localparam logic [5:0] FnDivu    = 6'h1B;
    localparam logic [5:0] FnAdd     = 6'h20;
    localparam logic [5:0] FnAddu    = 6'h21;
    localparam logic [5:0] FnSub     = 6'h22;
    localparam logic [5:0] FnSubu    = 6'h23;
    localparam logic [5:0] FnAnd     = 6'h24;
    localparam logic [5:0] FnOr      = 6'h25;
    localparam logic [5:0] FnXor     = 6'h26;
    localparam logic [5:0] FnNor     = 6'h27;
    localparam logic [5:0] FnSlt     = 6'h2A;
    localparam logic [5:0] FnSltu    = 6'h2B;

    // REGIMM rt codes
    localparam logic [4:0] RtBltz    = 5'h00;
    localparam logic [4:0] RtBgez    = 5'h01;
    localparam logic [4:0] RtBltzal  = 5'h10;
    localparam logic [4:0] RtBgezal  = 5'h11;

    // ALU ops
    localparam logic [3:0] AluAdd  = 4'd0;
    localparam logic [3:0] AluSub  = 4'd1;
    localparam logic [3:0] AluAnd  = 4'd2;
    localparam logic [3:0] AluOr   = 4'd3;
    localparam logic [3:0] AluXor  = 4'd4;
    localparam logic [3:0] AluNor  = 4'd5;
    localparam logic [3:0] AluSlt  = 4'd6;
    localparam logic [3:0] AluSltu = 4'd7;
    localparam logic [3:0] AluSll  = 4'd8;
    localparam logic [3:0] AluSrl  = 4'd9;
    localparam logic [3:0] AluSra  = 4'd10;
    localparam logic [3:0] AluLui  = 4'd11;

    // HI/LO unit ops
    localparam logic [1:0] HiloNone = 2'd0;
    localparam logic [1:0] HiloMult = 2'd1;
    localparam logic [1:0] HiloDiv  = 2'd2;
    localparam logic [1:0] HiloMove = 2'd3;

    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_write;
        logic       alu_src;
        logic       reg_dest;
        logic       syscall;
        logic       is_byte;
        logic       link_reg;
        logic [3:0] alu_op;
        logic [1:0] hilo_op;
        logic       valid;
        logic       illegal;
    } ctrl_t;

    typedef enum logic {StIdle, StBusy} state_e;

    ctrl_t            dec;
    ctrl_t            ctrl_q;
    logic             legal;
    logic             is_hilo;   // touches HI/LO: must wait for the unit
    logic             is_start;  // MULT*/DIV*: starts the unit
    logic             unit_issue;
    logic [CNT_W-1:0] cnt_load;
    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             done_q;

    // Combinational decode of D
    always_comb begin
        dec          = '0;
        dec.valid    = 1'b1;
        legal        = 1'b1;
        is_hilo      = 1'b0;
        is_start     = 1'b0;
        case (opcode)
            OpSpecial: begin
                case (funct)
                    FnSll, FnSllv: begin
                        dec.reg_write = 1'b1; dec.reg_dest = 1'b1; dec.alu_op = AluSll;
                    end
                    FnSrl, FnSrlv: begin
                        dec.reg_write = 1'b1; dec.reg_dest = 1'b1; dec.alu_op = AluSrl;
                    end
                    FnSra, FnSrav: begin
                        dec.reg_write = 1'b1; dec.reg_dest = 1'b1; dec.alu_op = AluSra;
                    end
                    FnJr: begin
                    end
                    FnJalr: begin
                        dec.reg_write = 1'b1; dec.reg_dest = 1'b1; dec.link_reg = 1'b1;
                    end
                    FnSyscall: dec.syscall = 1'b1;
                    FnMfhi, FnMflo: begin
                        dec.reg_write = 1'b1; dec.reg_dest = 1'b1; is_hilo = 1'b1;
                    end
                    FnMthi, FnMtlo: begin
                        dec.hilo_op = HiloMove; is_hilo = 1'b1;
                    end
                    FnMult, FnMultu: begin
                        dec.hilo_op = HiloMult; is_hilo = 1'b1; is_start = 1'b1;
                    end
                    FnDiv, FnDivu: begin
                        dec.hilo_op = HiloDiv; is_hilo = 1'b1; is_start = 1'b1;
                    end
                    FnAdd, FnAddu: begin
                        dec.reg_write = 1'b1; dec.reg_dest = 1'b1; dec.alu_op = AluAdd;
                    end
                    FnSub, FnSubu: begin
                        dec.reg_write = 1'b1; dec.reg_dest = 1'b1; dec.alu_op = AluSub;
                    end
                    FnAnd: begin
                        dec.reg_write = 1'b1; dec.reg_dest = 1'b1; dec.alu_op = AluAnd;
                    end
                    FnOr: begin
                        dec.reg_write = 1'b1; dec.reg_dest = 1'b1; dec.alu_op = AluOr;
                    end
                    FnXor: begin
                        dec.reg_write = 1'b1; dec.reg_dest = 1'b1; dec.alu_op = AluXor;
                    end
                    FnNor: begin
                        dec.reg_write = 1'b1; dec.reg_dest = 1'b1; dec.alu_op = AluNor;
                    end
                    FnSlt: begin
                        dec.reg_write = 1'b1; dec.reg_dest = 1'b1; dec.alu_op = AluSlt;
                    end
                    FnSltu: begin
                        dec.reg_write = 1'b1; dec.reg_dest = 1'b1; dec.alu_op = AluSltu;
                    end
                    default: legal = 1'b0;
                endcase
            end
            // REGIMM branches select their sub-op through rt, not funct
            OpRegimm: begin
                case (reg_rt_id)
                    RtBltz, RtBgez: dec.alu_op = AluSub;
                    RtBltzal, RtBgezal: begin
                        dec.alu_op = AluSub; dec.reg_write = 1'b1; dec.link_reg = 1'b1;
                    end
                    default: legal = 1'b0;
                endcase
            end
            OpJ: begin
            end
            OpJal: begin
                dec.reg_write = 1'b1; dec.link_reg = 1'b1;
            end
            OpBeq, OpBne, OpBlez, OpBgtz: dec.alu_op = AluSub;
            OpAddi, OpAddiu: begin
                dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.alu_op = AluAdd;
            end
            OpSlti: begin
                dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.alu_op = AluSlt;
            end
            OpSltiu: begin
                dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.alu_op = AluSltu;
            end
            OpAndi: begin
                dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.alu_op = AluAnd;
            end
            OpOri: begin
                dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.alu_op = AluOr;
            end
            OpXori: begin
                dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.alu_op = AluXor;
            end
            OpLui: begin
                dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.alu_op = AluLui;
            end
            OpLb, OpLbu: begin
                dec.reg_write = 1'b1; dec.mem_to_reg = 1'b1; dec.alu_src = 1'b1;
                dec.is_byte   = 1'b1;
            end
            OpLw: begin
                dec.reg_write = 1'b1; dec.mem_to_reg = 1'b1; dec.alu_src = 1'b1;
            end
            OpSb: begin
                dec.mem_write = 1'b1; dec.alu_src = 1'b1; dec.is_byte = 1'b1;
            end
            OpSw: begin
                dec.mem_write = 1'b1; dec.alu_src = 1'b1;
            end
            default: legal = 1'b0;
        endcase
        // Undecoded: bubble-equivalent bundle flagged illegal; the unit ignores it
        if (!legal) begin
            dec         = '0;
            dec.valid   = 1'b1;
            dec.illegal = 1'b1;
            is_hilo     = 1'b0;
            is_start    = 1'b0;
        end
    end

    assign hilo_busy = (state_q == StBusy);
    assign hilo_done = done_q;

    // The final busy cycle releases the hazard so the waiting op issues as busy falls
    assign stallD     = hilo_busy & ~done_q & validD & is_hilo;
    assign unit_issue = validD & ~flushE & ~stallD & ~stallE & is_start;
    assign cnt_load   = (dec.hilo_op == HiloDiv) ? CNT_W'(DIV_CYCLES - 1)
                                                 : CNT_W'(MULT_CYCLES - 1);

    // Unit sequencer; runs independently of stallE/flushE once started
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (unit_issue) begin
                        state_q <= StBusy;
                        cnt_q   <= cnt_load;
                    end
                end
                StBusy: begin
                    if (cnt_q == '0) begin
                        // Back-to-back op reloads without passing through idle
                        if (unit_issue) begin
                            cnt_q <= cnt_load;
                        end else begin
                            state_q <= StIdle;
                        end
                    end else begin
                        cnt_q  <= cnt_q - 1'b1;
                        done_q <= (cnt_q == CNT_W'(1));
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // D->E pipeline register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ctrl_q <= '0;
        end else if (!stallE) begin
            if (flushE || stallD || !validD) begin
                ctrl_q <= '0;
            end else begin
                ctrl_q <= dec;
            end
        end
    end

    assign reg_writeE  = ctrl_q.reg_write;
    assign mem_to_regE = ctrl_q.mem_to_reg;
    assign mem_writeE  = ctrl_q.mem_write;
    assign alu_srcE    = ctrl_q.alu_src;
    assign reg_destE   = ctrl_q.reg_dest;
    assign syscallE    = ctrl_q.syscall;
    assign is_byteE    = ctrl_q.is_byte;
    assign link_regE   = ctrl_q.link_reg;
    assign alu_opE     = ctrl_q.alu_op;
    assign hilo_opE    = ctrl_q.hilo_op;
    assign validE      = ctrl_q.valid;
    assign illegalE    = ctrl_q.illegal;

endmodule

// File: tb/tb_hilo_control_sequencer.sv
// Directed bench for hilo_control_sequencer (DIV_CYCLES=32, MULT_CYCLES=4).
module tb_hilo_control_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] opcode = '0;
    logic [5:0] funct = '0;
    logic [4:0] reg_rt_id = '0;
    logic       validD = 1'b0;
    logic       flushE = 1'b0;
    logic       stallE = 1'b0;
    logic       reg_writeE, mem_to_regE, mem_writeE, alu_srcE, reg_destE;
    logic       syscallE, is_byteE, link_regE, validE, illegalE;
    logic [3:0] alu_opE;
    logic [1:0] hilo_opE;
    logic       stallD, hilo_busy, hilo_done;

    int n_checks = 0;
    int n_pass   = 0;

    hilo_control_sequencer dut (
        .clock      (clock),
        .reset      (reset),
        .opcode     (opcode),
        .funct      (funct),
        .reg_rt_id  (reg_rt_id),
        .validD     (validD),
        .flushE     (flushE),
        .stallE     (stallE),
        .reg_writeE (reg_writeE),
        .mem_to_regE(mem_to_regE),
        .mem_writeE (mem_writeE),
        .alu_srcE   (alu_srcE),
        .reg_destE  (reg_destE),
        .syscallE   (syscallE),
        .is_byteE   (is_byteE),
        .link_regE  (link_regE),
        .alu_opE    (alu_opE),
        .hilo_opE   (hilo_opE),
        .validE     (validE),
        .illegalE   (illegalE),
        .stallD     (stallD),
        .hilo_busy  (hilo_busy),
        .hilo_done  (hilo_done)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rt,
                         input logic v);
        opcode    = op;
        funct     = fn;
        reg_rt_id = rt;
        validD    = v;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int stall_cnt;
        int done_cnt;
        int done_at;
        int lat;

        // Reset state
        repeat (2) tick();
        check_eq("rst_validE", 32'(validE), 0);
        check_eq("rst_busy", 32'(hilo_busy), 0);
        check_eq("rst_done", 32'(hilo_done), 0);
        reset = 1'b1;
        repeat (3) tick();
        check_eq("idle_validE", 32'(validE), 0);
        check_eq("idle_regw", 32'(reg_writeE), 0);
        check_eq("idle_stallD", 32'(stallD), 0);
        check_eq("idle_busy", 32'(hilo_busy), 0);

        // ADDIU
        drive(6'h09, 6'h00, 5'h00, 1'b1);
        tick();
        check_eq("addiu_regw", 32'(reg_writeE), 1);
        check_eq("addiu_alusrc", 32'(alu_srcE), 1);
        check_eq("addiu_regdst", 32'(reg_destE), 0);
        check_eq("addiu_validE", 32'(validE), 1);
        check_eq("addiu_aluop", 32'(alu_opE), 0);

        // DIV then MFHI: 31 stalled cycles, done on the 32nd, MFHI in E 32 edges after issue
        drive(6'h00, 6'h1A, 5'h00, 1'b1);
        tick();
        check_eq("div_busy", 32'(hilo_busy), 1);
        check_eq("div_hiloop", 32'(hilo_opE), 2);
        check_eq("div_validE", 32'(validE), 1);
        drive(6'h00, 6'h10, 5'h00, 1'b1);
        stall_cnt = 0;
        done_cnt  = 0;
        done_at   = 0;
        lat       = 0;
        for (int i = 1; i <= 40 && lat == 0; i++) begin
            #1;
            if (stallD) stall_cnt++;
            if (hilo_done) begin
                done_cnt++;
                done_at = i - 1;
            end
            tick();
            if (validE) lat = i;
        end
        check_eq("mfhi_stall_cycles", 32'(stall_cnt), 31);
        check_eq("div_done_count", 32'(done_cnt), 1);
        check_eq("div_done_cycle", 32'(done_at), 31);
        check_eq("mfhi_latency", 32'(lat), 32);
        check_eq("mfhi_regdst", 32'(reg_destE), 1);
        check_eq("mfhi_hiloop", 32'(hilo_opE), 0);
        check_eq("div_busy_fell", 32'(hilo_busy), 0);

        // MULT, ADDU, LW proceed while busy; second MULT stalls then reloads with no idle
        drive(6'h00, 6'h18, 5'h00, 1'b1);
        tick();
        check_eq("mult_hiloop", 32'(hilo_opE), 1);
        check_eq("mult_busy", 32'(hilo_busy), 1);
        drive(6'h00, 6'h21, 5'h00, 1'b1);
        #1;
        check_eq("addu_nostall", 32'(stallD), 0);
        tick();
        check_eq("addu_regdst", 32'(reg_destE), 1);
        check_eq("addu_validE", 32'(validE), 1);
        check_eq("addu_busy", 32'(hilo_busy), 1);
        drive(6'h23, 6'h00, 5'h00, 1'b1);
        tick();
        check_eq("lw_memtoreg", 32'(mem_to_regE), 1);
        check_eq("lw_alusrc", 32'(alu_srcE), 1);
        check_eq("lw_busy", 32'(hilo_busy), 1);
        drive(6'h00, 6'h18, 5'h00, 1'b1);
        #1;
        check_eq("mult2_stall", 32'(stallD), 1);
        tick();
        check_eq("mult_done", 32'(hilo_done), 1);
        check_eq("mult2_bubble", 32'(validE), 0);
        #1;
        check_eq("mult2_release", 32'(stallD), 0);
        tick();
        check_eq("mult2_busy", 32'(hilo_busy), 1);
        check_eq("mult2_issued", 32'(hilo_opE), 1);
        check_eq("mult2_done_low", 32'(hilo_done), 0);
        drive(6'h00, 6'h00, 5'h00, 1'b0);
        repeat (3) tick();
        check_eq("mult2_done", 32'(hilo_done), 1);
        tick();
        check_eq("mult2_idle", 32'(hilo_busy), 0);

        // flushE with stallD: stall still driven, E gets a bubble
        drive(6'h00, 6'h19, 5'h00, 1'b1);
        tick();
        drive(6'h00, 6'h12, 5'h00, 1'b1);
        flushE = 1'b1;
        #1;
        check_eq("flush_stallD", 32'(stallD), 1);
        tick();
        check_eq("flush_stall_bubble", 32'(validE), 0);
        flushE = 1'b0;
        drive(6'h00, 6'h00, 5'h00, 1'b0);
        repeat (3) tick();
        check_eq("multu_idle", 32'(hilo_busy), 0);

        // DIV flushed in D never starts the unit
        drive(6'h00, 6'h1A, 5'h00, 1'b1);
        flushE = 1'b1;
        tick();
        check_eq("flush_div_validE", 32'(validE), 0);
        check_eq("flush_div_busy", 32'(hilo_busy), 0);
        flushE = 1'b0;

        // stallE holds E but the unit still completes
        drive(6'h00, 6'h18, 5'h00, 1'b1);
        tick();
        stallE = 1'b1;
        drive(6'h00, 6'h00, 5'h00, 1'b0);
        repeat (3) tick();
        check_eq("stallE_done", 32'(hilo_done), 1);
        check_eq("stallE_hold", 32'(hilo_opE), 1);
        tick();
        check_eq("stallE_idle", 32'(hilo_busy), 0);
        check_eq("stallE_hold2", 32'(validE), 1);
        stallE = 1'b0;
        tick();
        check_eq("stallE_release", 32'(validE), 0);

        // Decode spot checks
        drive(6'h28, 6'h00, 5'h00, 1'b1);
        tick();
        check_eq("sb_memw", 32'(mem_writeE), 1);
        check_eq("sb_byte", 32'(is_byteE), 1);
        check_eq("sb_regw", 32'(reg_writeE), 0);
        drive(6'h01, 6'h00, 5'h11, 1'b1);
        tick();
        check_eq("bgezal_link", 32'(link_regE), 1);
        check_eq("bgezal_regw", 32'(reg_writeE), 1);
        check_eq("bgezal_aluop", 32'(alu_opE), 1);
        drive(6'h00, 6'h0C, 5'h00, 1'b1);
        tick();
        check_eq("syscall", 32'(syscallE), 1);
        drive(6'h3F, 6'h00, 5'h00, 1'b1);
        tick();
        check_eq("illegal_flag", 32'(illegalE), 1);
        check_eq("illegal_regw", 32'(reg_writeE), 0);
        check_eq("illegal_validE", 32'(validE), 1);
        check_eq("illegal_busy", 32'(hilo_busy), 0);

        // Reset mid-DIV aborts at once and no done pulse follows
        drive(6'h00, 6'h1A, 5'h00, 1'b1);
        tick();
        drive(6'h09, 6'h00, 5'h00, 1'b1);
        repeat (10) tick();
        check_eq("middiv_busy", 32'(hilo_busy), 1);
        check_eq("middiv_validE", 32'(validE), 1);
        #2;
        reset = 1'b0;
        #1;
        check_eq("async_busy", 32'(hilo_busy), 0);
        check_eq("async_validE", 32'(validE), 0);
        check_eq("async_regw", 32'(reg_writeE), 0);
        repeat (2) tick();
        reset = 1'b1;
        drive(6'h00, 6'h00, 5'h00, 1'b0);
        done_cnt = 0;
        repeat (40) begin
            tick();
            if (hilo_done) done_cnt++;
        end
        check_eq("abort_no_done", 32'(done_cnt), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
